pwm_duty_meter: RTL

Receive-side counterpart of the breathing-LED PWM generator. Samples an external PWM line, measures high time and period in sys_clk cycles, and publishes each completed measurement with a one-cycle valid strobe. Detects a line stuck high or low by timeout. Sits in the same custom AXI-wrapped IP family; its outputs are read back through registers, e.g. for loopback checking of the LED output.

---
 rtl/breath_led_pkg.sv | 32 +++
 rtl/pwm_in_sync.sv | 47 ++++
 rtl/pwm_duty_meter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/breath_led_pkg.sv
// ---------------------------------------------------------------------------
// breath_led_pkg
//   Shared constants for the breathing-LED PWM family (generator and meter).
//   Keeping the counter width, the stuck-line timeout and the meter FSM
//   encodings in one place lets the generator and the duty meter agree on
//   timing.
//
//   Contents:
//     CNT_W_DEF        default measurement/counter width
//     TIMEOUT_CYC_DEF  default cycles without an edge before a line is stuck
//     ST_*             2-bit meter FSM encodings
//     meter_state_e    typed FSM state built on those encodings
// ---------------------------------------------------------------------------
package breath_led_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  // 1 ms at 50 MHz
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StWaitRise = ST_WAIT_RISE,
    StHigh     = ST_HIGH,
    StLow      = ST_LOW
  } meter_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// ---------------------------------------------------------------------------
// pwm_in_sync
//   Brings the asynchronous PWM line into the sys_clk domain and derives
//   single-cycle edge strobes. Two synchronizer flops are followed by one
//   delay flop; edges compare the synchronized level with its delayed copy,
//   so a pulse that is one cycle wide after synchronization still yields a
//   rise strobe followed by a fall strobe. Pin-to-edge-registered latency is
//   three cycles.
//
//   Ports:
//     sys_clk    in   system clock
//     sys_rst_n  in   asynchronous active-low reset, clears all flops
//     pwm_in     in   asynchronous PWM input
//     level      out  synchronized line level
//     rise       out  one-cycle strobe on a synchronized 0->1 transition
//     fall       out  one-cycle strobe on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module pwm_in_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= pwm_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~dly_q;
  assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// ---------------------------------------------------------------------------
// pwm_duty_meter
//   Receive-side counterpart of the breathing-LED PWM generator. Measures the
//   high time and rise-to-rise period of an external PWM line in sys_clk
//   cycles and publishes each completed period with a one-cycle strobe.
//   A line that shows no edge for TIMEOUT_CYC cycles is flagged as stuck
//   high or stuck low; the flag clears on the next detected edge.
//
//   Parameters:
//     CNT_W        width of the accumulators and result outputs
//     TIMEOUT_CYC  cycles without an edge before a stuck flag (< 2**CNT_W)
//
//   Ports:
//     sys_clk     in   system clock (50 MHz)
//     sys_rst_n   in   asynchronous active-low reset
//     pwm_in      in   asynchronous PWM input
//     meas_en     in   measurement enable; low forces IDLE
//     high_cnt    out  high time of the last completed period (cycles)
//     period_cnt  out  rise-to-rise period of the last completed period
//     meas_valid  out  one-cycle pulse when high_cnt/period_cnt update
//     stuck_hi    out  line held high for TIMEOUT_CYC cycles (sticky)
//     stuck_lo    out  line held low for TIMEOUT_CYC cycles (sticky)
// ---------------------------------------------------------------------------
module pwm_duty_meter
  import breath_led_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  // Counters saturate at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  logic sync_level;
  logic sync_rise;
  logic sync_fall;
  logic any_edge;
  logic timeout;

  meter_state_e     state_q;
  logic [CNT_W-1:0] hi_acc_q;
  logic [CNT_W-1:0] per_acc_q;
  logic [CNT_W-1:0] idle_cnt_q;

  pwm_in_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pwm_in    (pwm_in),
    .level     (sync_level),
    .rise      (sync_rise),
    .fall      (sync_fall)
  );

  assign any_edge = sync_rise | sync_fall;
  // An edge arriving in the same cycle as the timeout wins.
  assign timeout  = ~any_edge & (idle_cnt_q == TimeoutLast);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      hi_acc_q   <= '0;
      per_acc_q  <= '0;
      idle_cnt_q <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (!meas_en) begin
        // Disable takes priority, including over a publishing rise.
        state_q    <= StIdle;
        hi_acc_q   <= '0;
        per_acc_q  <= '0;
        idle_cnt_q <= '0;
        stuck_hi   <= 1'b0;
        stuck_lo   <= 1'b0;
      end else if (state_q == StIdle) begin
        state_q    <= StWaitRise;
        hi_acc_q   <= '0;
        per_acc_q  <= '0;
        idle_cnt_q <= '0;
        stuck_hi   <= 1'b0;
        stuck_lo   <= 1'b0;
      end else if (timeout) begin
        // Abandon the partial period; idle_cnt holds at its limit so the
        // condition persists until an edge shows up.
        if (sync_level) begin
          stuck_hi <= 1'b1;
        end else begin
          stuck_lo <= 1'b1;
        end
        hi_acc_q  <= '0;
        per_acc_q <= '0;
        state_q   <= StWaitRise;
      end else begin
        if (any_edge) begin
          idle_cnt_q <= '0;
          stuck_hi   <= 1'b0;
          stuck_lo   <= 1'b0;
        end else begin
          idle_cnt_q <= sat_inc(idle_cnt_q);
        end

        unique case (state_q)
          StWaitRise: begin
            if (sync_rise) begin
              hi_acc_q  <= CntOne;
              per_acc_q <= CntOne;
              state_q   <= StHigh;
            end
          end
          StHigh: begin
            if (sync_fall) begin
              per_acc_q <= sat_inc(per_acc_q);
              state_q   <= StLow;
            end else begin
              hi_acc_q  <= sat_inc(hi_acc_q);
              per_acc_q <= sat_inc(per_acc_q);
            end
          end
          StLow: begin
            if (sync_rise) begin
              // Publish and immediately start the next period: the rise
              // cycle counts as cycle 1 of the new high phase.
              high_cnt   <= hi_acc_q;
              period_cnt <= per_acc_q;
              meas_valid <= 1'b1;
              hi_acc_q   <= CntOne;
              per_acc_q  <= CntOne;
              state_q    <= StHigh;
            end else begin
              per_acc_q <= sat_inc(per_acc_q);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
